// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch
// Purpose  : Instruction prefetch unit. Streams sequential instruction fetches
//            from a 1-cycle-latency instruction memory into a small FIFO that
//            feeds the decode stage. Supports branch redirect (flush plus
//            refetch, stale responses killed by an epoch bit) and pipeline
//            halt (all state frozen, in-flight response dropped and re-issued).
// Ports    : clk, rst_n (async, active low)
//            halt_in, redirect, redirect_pc[31:0]  - pipeline control
//            imem_req, imem_addr[AW-1:0]            - fetch request
//            imem_valid, imem_rdata[31:0]           - fetch response
//            dec_valid, dec_ready, dec_instr, dec_npc - decode handshake
//            level[$clog2(DEPTH):0]                 - FIFO occupancy
// Params   : DEPTH (FIFO entries, power of two >= 2), AW (imem address width)
// Options  : INSTR_PREFETCH_HLT_STOP_EN - an instruction with opcode
//            [31:26] = 6'b111111 stops fetching until redirect or reset.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     halt_in,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic                     imem_valid,
  input  logic [31:0]              imem_rdata,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_instr,
  output logic [31:0]              dec_npc,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW:0] DEPTH_C = (LW+1)'(DEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          outst_q, outst_d;
  logic          epoch_q, epoch_d;
  logic          req_epoch_q, req_epoch_d;
  logic          stop_q, stop_d;

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_npc   [DEPTH];

  logic          rsp_ok;
  logic          push;
  logic          pop;
  logic          hlt_now;
  logic [LW:0]   credit;

  // A response is live only if a request was sampled last edge and no
  // redirect has happened since (epoch unchanged).
  assign rsp_ok = outst_q && imem_valid && (req_epoch_q == epoch_q);
  assign push   = rsp_ok && !halt_in && !redirect;
  assign pop    = dec_valid && dec_ready && !redirect && !halt_in;

`ifdef INSTR_PREFETCH_HLT_STOP_EN
  // The arriving word is a stop opcode: block the request that would
  // otherwise go out at the same edge the stop word is pushed.
  assign hlt_now = rsp_ok && (imem_rdata[31:26] == 6'b111111);
`else
  assign hlt_now = 1'b0;
`endif

  // Occupied entries plus the in-flight word must leave room for one more.
  assign credit   = {1'b0, level_q} + {{LW{1'b0}}, outst_q};
  assign imem_req = rst_n && !halt_in && !redirect && !stop_q && !hlt_now &&
                    (credit < DEPTH_C);

  assign imem_addr = fpc_q[AW-1:0];
  assign level     = level_q;
  assign dec_valid = (level_q != '0);
  assign dec_instr = dec_valid ? mem_instr[rd_ptr_q] : 32'd0;
  assign dec_npc   = dec_valid ? mem_npc[rd_ptr_q]   : 32'd0;

  always_comb begin
    fpc_d       = fpc_q;
    level_d     = level_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    epoch_d     = epoch_q;
    req_epoch_d = req_epoch_q;
    stop_d      = stop_q;
    // Memory always answers exactly one cycle later, so the only thing in
    // flight after an edge is the request sampled at that edge.
    outst_d     = imem_req;

    if (imem_req) begin
      fpc_d       = fpc_q + 32'd1;
      req_epoch_d = epoch_q;
    end

    if (redirect) begin
      fpc_d    = redirect_pc;
      epoch_d  = ~epoch_q;
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      stop_d   = 1'b0;
    end else begin
      // A live response landing during halt is dropped; step the fetch
      // pointer back onto it so it is fetched again once halt releases.
      if (halt_in && outst_q && (req_epoch_q == epoch_q)) begin
        fpc_d = fpc_q - 32'd1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
`ifdef INSTR_PREFETCH_HLT_STOP_EN
        if (imem_rdata[31:26] == 6'b111111) begin
          stop_d = 1'b1;
        end
`endif
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q       <= 32'd0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      outst_q     <= 1'b0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      fpc_q       <= fpc_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      outst_q     <= outst_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
      stop_q      <= stop_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible while level != 0.
  // fpc_q at the push edge is the request address + 1, i.e. the next PC.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= imem_rdata;
      mem_npc[wr_ptr_q]   <= fpc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_prefetch
// Purpose  : Self-checking bench for instr_prefetch. A 1-cycle memory model
//            answers requests; a stream model tracks which PC decode must
//            see next and checks every accepted instruction, plus per-cycle
//            invariants and hand-computed directed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch;

  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic        clk;
  logic        rst_n;
  logic        halt_in;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [AW-1:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_npc;
  logic [$clog2(DEPTH):0] level;

  int          checks   = 0;
  int          failures = 0;
  logic        hlt_mode = 1'b0;
  logic        watch    = 1'b0;
  logic        saw_beyond5;
  logic [31:0] exp_pc   = 32'd0;

  instr_prefetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .halt_in    (halt_in),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_instr  (dec_instr),
    .dec_npc    (dec_npc),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: word i holds i, except address 5 holds a stop opcode
  // while hlt_mode is set.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (hlt_mode && (a[9:0] == 10'd5)) return 32'hFC00_0005;
    return {22'd0, a[9:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One-cycle-latency instruction memory.
  always @(posedge clk) begin
    imem_valid <= imem_req;
    imem_rdata <= memword({22'd0, imem_addr});
    if (!watch) saw_beyond5 <= 1'b0;
    else if (imem_req && (imem_addr > 10'd5) && (imem_addr < 10'd64)) saw_beyond5 <= 1'b1;
  end

  // Stream model and per-cycle invariants.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = 32'd0;
    end else begin
      check("valid_vs_level", 32'(dec_valid), 32'(level != 0));
      check("level_bound", 32'(level <= DEPTH), 32'd1);
      check("no_overflow", 32'((32'(level) + 32'(imem_valid)) <= DEPTH), 32'd1);
      if (halt_in || redirect) check("req_blocked", 32'(imem_req), 32'd0);
      if (dec_valid) check("head_pair", dec_instr, memword(dec_npc - 32'd1));
      if (dec_valid && dec_ready && !redirect && !halt_in) begin
        check("pop_instr", dec_instr, memword(exp_pc));
        check("pop_npc", dec_npc, exp_pc + 32'd1);
        exp_pc = exp_pc + 32'd1;
      end
      if (redirect) exp_pc = redirect_pc;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; halt_in = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; dec_ready = 1'b1;

    // Reset values
    repeat (3) cyc();
    #1;
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_dec_instr", dec_instr, 32'd0);
    check("rst_dec_npc", dec_npc, 32'd0);

    // Release: request address 0 in cycle 0, dec_valid in cycle 2
    rst_n = 1'b1;
    #1;
    check("c0_req", 32'(imem_req), 32'd1);
    check("c0_addr", 32'(imem_addr), 32'd0);
    cyc(); #1;
    check("c1_dec_valid", 32'(dec_valid), 32'd0);
    cyc(); #1;
    check("c2_dec_valid", 32'(dec_valid), 32'd1);
    check("c2_dec_instr", dec_instr, 32'd0);
    check("c2_dec_npc", dec_npc, 32'd1);
    repeat (3) cyc(); #1;
    check("c5_dec_instr", dec_instr, 32'd3);

    // Back-pressure: FIFO fills to DEPTH and fetching stops
    dec_ready = 1'b0;
    repeat (10) cyc();
    #1;
    check("sat_level", 32'(level), 32'd4);
    check("sat_req", 32'(imem_req), 32'd0);
    dec_ready = 1'b1;
    repeat (8) cyc();

    // Redirect while level = 3 with one response in flight
    redirect_pc = 32'h100; redirect = 1'b1; dec_ready = 1'b0;
    cyc();
    redirect = 1'b0;
    begin : wait_lvl3
      for (int i = 0; i < 20; i++) begin
        if (level == 3) disable wait_lvl3;
        cyc();
      end
    end
    #1;
    check("pre_redir_level", 32'(level), 32'd3);
    check("pre_redir_inflight", 32'(imem_valid), 32'd1);
    redirect_pc = 32'h40; redirect = 1'b1;
    cyc();
    redirect = 1'b0;
    #1;
    check("post_redir_level", 32'(level), 32'd0);
    dec_ready = 1'b1;
    begin : wait_dv
      for (int i = 0; i < 10; i++) begin
        if (dec_valid) disable wait_dv;
        cyc(); #1;
      end
    end
    check("redir_dec_valid", 32'(dec_valid), 32'd1);
    check("redir_dec_instr", dec_instr, 32'h40);
    check("redir_dec_npc", dec_npc, 32'h41);
    repeat (4) cyc();

    // Address wrap at 2^AW
    redirect_pc = 32'd1022; redirect = 1'b1;
    cyc();
    redirect = 1'b0;
    #1; check("wrap_addr0", 32'(imem_addr), 32'd1022);
    cyc(); #1; check("wrap_addr1", 32'(imem_addr), 32'd1023);
    cyc(); #1; check("wrap_addr2", 32'(imem_addr), 32'd0);
    check("wrap_npc0", dec_npc, 32'd1023);
    cyc(); #1; check("wrap_npc1", dec_npc, 32'd1024);
    cyc(); #1; check("wrap_npc2", dec_npc, 32'd1025);
    check("wrap_instr2", dec_instr, 32'd0);

    // Halt for 3 cycles with a request in flight
    repeat (3) cyc();
    halt_in = 1'b1;
    #1; check("halt_req", 32'(imem_req), 32'd0);
    repeat (3) cyc();
    halt_in = 1'b0;
    repeat (8) cyc();

    // Reset mid-stream
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(dec_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_instr", dec_instr, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", 32'(imem_addr), 32'd0);
    repeat (6) cyc();

    // Stop opcode at address 5
    redirect_pc = 32'd0; redirect = 1'b1;
    cyc();
    redirect = 1'b0; hlt_mode = 1'b1; watch = 1'b1;
    repeat (16) cyc();
    #1;
`ifdef INSTR_PREFETCH_HLT_STOP_EN
    check("stop_no_fetch_beyond5", 32'(saw_beyond5), 32'd0);
    check("stop_delivered_through5", exp_pc, 32'd6);
    check("stop_dec_valid", 32'(dec_valid), 32'd0);
    check("stop_req", 32'(imem_req), 32'd0);
`else
    check("nostop_fetch6", 32'(saw_beyond5), 32'd1);
    check("nostop_delivered_past5", 32'(exp_pc > 32'd6), 32'd1);
`endif
    watch = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries (power of two, minimum 2).
REQ-002 The block SHALL have parameter AW, default 10, meaning instruction-memory word-address width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port halt_in  input  1  pipeline halt; freezes all state.
REQ-006 The block SHALL have port redirect  input  1  branch taken; flush and refetch.
REQ-007 The block SHALL have port redirect_pc  input  32  word address of the branch target.
REQ-008 The block SHALL have port imem_req  output  1  fetch request this cycle.
REQ-009 The block SHALL have port imem_addr  output  AW  word address of the request, equal to fpc[AW-1:0].
REQ-010 The block SHALL have port imem_valid  input  1  response valid, exactly one cycle after a sampled request.
REQ-011 The block SHALL have port imem_rdata  input  32  response instruction word.
REQ-012 The block SHALL have port dec_valid  output  1  FIFO head holds an instruction.
REQ-013 The block SHALL have port dec_ready  input  1  decode stage accepts the head.
REQ-014 The block SHALL have port dec_instr  output  32  head instruction.
REQ-015 The block SHALL have port dec_npc  output  32  head fetch address + 1.
REQ-016 The block SHALL have port level  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 The block SHALL hold a 32-bit fetch pointer fpc that increments by 1 on every issued request and wraps modulo 2^32; imem_addr wraps modulo 2^AW.
REQ-018 The block SHALL assert imem_req combinationally when !halt_in, !redirect, not stopped, and level + outstanding < DEPTH.
REQ-019 The block SHALL keep at most one outstanding request; a request issued at edge E returns at edge E+1.
REQ-020 The block SHALL push {imem_rdata, request address + 1} into the FIFO at the edge where imem_valid is high and the response is not discarded.
REQ-021 The block SHALL drive dec_valid = (level != 0), with dec_instr and dec_npc taken from the head entry; no same-cycle bypass from imem_rdata.
REQ-022 The block SHALL pop the head at an edge where dec_valid && dec_ready && !redirect && !halt_in.
REQ-023 The block SHALL support a simultaneous push and pop in one edge, leaving level unchanged.
REQ-024 The block SHALL guarantee by credit accounting that a push never occurs while the FIFO is full; the FIFO SHALL never overflow.
REQ-025 On redirect, the block SHALL, at that edge, empty the FIFO, set fpc to redirect_pc, and discard any response returning at the next edge via an epoch bit.
REQ-026 Redirect SHALL take priority over push, pop and stop; the first request to redirect_pc is issued in the cycle after the redirect edge.
REQ-027 While halt_in is high, the block SHALL hold fpc, FIFO, level, epoch and stop state, and SHALL deassert imem_req; responses arriving during halt SHALL be dropped and the request re-issued after halt_in falls.
REQ-028 Latency SHALL be: request in cycle N, FIFO push at edge ending N+1, dec_valid high in cycle N+2.

Reset
REQ-029 Asserting rst_n low SHALL asynchronously clear fpc to 0, level to 0, outstanding to 0, epoch to 0 and stop to 0, with dec_valid low, imem_req low and dec_instr/dec_npc at 0.
REQ-030 Reset asserted mid-operation SHALL discard the FIFO and all in-flight responses; the first request (address 0) SHALL be issued in the first cycle after rst_n rises.

Configuration
REQ-031 With macro INSTR_PREFETCH_HLT_STOP_EN defined, pushing an instruction with [31:26] = 6'b111111 SHALL set stop, blocking further requests until redirect or reset while the FIFO continues to drain.
REQ-032 Without INSTR_PREFETCH_HLT_STOP_EN, the block SHALL treat opcode 6'b111111 as ordinary data and continue fetching.

Verification
REQ-033 Reset release with memory[i] = i, dec_ready = 1 -> dec_valid rises in cycle 2; dec_instr sequence 0,1,2,… with dec_npc = instr + 1, one instruction per cycle.
REQ-034 dec_ready = 0 for 10 cycles -> level saturates at 4, imem_req low, then 0..3 delivered in order once dec_ready = 1.
REQ-035 Redirect to 0x40 while level = 3 with one response in flight -> level 0 next cycle, in-flight word dropped, next dec_instr is memory[0x40] with dec_npc = 0x41.
REQ-036 fpc = 1022, free run -> imem_addr sequence 1022, 1023, 0; dec_npc sequence 1023, 1024, 1025.
REQ-037 With INSTR_PREFETCH_HLT_STOP_EN, HLT at address 5 -> no request beyond address 5, instructions through 5 delivered, then dec_valid stays low; without the macro, fetching continues to address 6.
REQ-038 halt_in high for 3 cycles while a request is in flight, and rst_n pulsed mid-stream -> no loss or duplication across halt; after reset, the first request goes to address 0.
